// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter.
//   XLEN          : datapath width of all address/data buses
//   MEM_*_DEF     : default downstream memory window
//   mem_owner_t   : which requester owns the response cycle
//   addr_in_window: window decode used by mem_range_check
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned XBYTES = XLEN / 8;

  localparam logic [XLEN-1:0] MEM_BASE_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] MEM_SIZE_DEF = 32'h0001_0000;
  localparam int unsigned     CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DATA,
    OWN_FETCH
  } mem_owner_t;

  // Unsigned wrap makes addresses below base land far above size.
  function automatic logic addr_in_window(input logic [XLEN-1:0] addr,
                                          input logic [XLEN-1:0] base,
                                          input logic [XLEN-1:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter.
//   d_* : load/store data port (cannot be stalled)
//   f_* : instruction-fetch port (req/gnt/rvalid handshake)
//   m_* : downstream synchronous memory port (1-cycle read latency)
// Modports: slave = arbiter view, master = surrounding system view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
;
  logic              d_req;
  logic [XLEN-1:0]   d_addr;
  logic              d_we;
  logic [XBYTES-1:0] d_byteen;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_err;

  logic              f_req;
  logic [XLEN-1:0]   f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [XLEN-1:0]   f_rdata;
  logic              f_err;

  logic              m_req;
  logic [XLEN-1:0]   m_addr;
  logic              m_we;
  logic [XBYTES-1:0] m_byteen;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN-1:0]   m_rdata;
  logic              m_err;

  modport slave (
    input  d_req, d_addr, d_we, d_byteen, d_wdata,
    input  f_req, f_addr,
    input  m_rdata, m_err,
    output d_rdata, d_err,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output m_req, m_addr, m_we, m_byteen, m_wdata
  );

  modport master (
    output d_req, d_addr, d_we, d_byteen, d_wdata,
    output f_req, f_addr,
    output m_rdata, m_err,
    input  d_rdata, d_err,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  m_req, m_addr, m_we, m_byteen, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_range_check.sv
// Combinational window decode: in_range_o is high when addr_i falls inside
// [MEM_BASE, MEM_BASE+MEM_SIZE).
//   addr_i     : byte address to test
//   in_range_o : address served by the downstream memory
module mem_range_check
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [XLEN-1:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [XLEN-1:0] MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic [XLEN-1:0] addr_i,
  output logic            in_range_o
);

  always_comb begin
    in_range_o = addr_in_window(addr_i, MEM_BASE, MEM_SIZE);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the data port (absolute
// priority, one access per 2-cycle transaction) and the fetch port.
// Out-of-window accesses are suppressed locally and answered with an error
// at the normal 1-cycle latency.
//   clk, rst_n      : core clock, asynchronous active-low reset
//   bus             : d_*/f_*/m_* bundle (slave modport)
//   fetch_stall_cnt : saturating count of cycles with f_req & ~f_gnt
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [XLEN-1:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [XLEN-1:0] MEM_SIZE = MEM_SIZE_DEF,
  parameter int unsigned     CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]     fetch_stall_cnt
);

  mem_owner_t       owner_q, owner_d;
  logic             d_req_q;
  logic             oor_q, oor_d;
  logic             d_we_q, d_we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic d_start;
  logic d_in_range;
  logic f_in_range;

  mem_range_check #(
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_rc_data (
    .addr_i     (bus.d_addr),
    .in_range_o (d_in_range)
  );

  mem_range_check #(
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_rc_fetch (
    .addr_i     (bus.f_addr),
    .in_range_o (f_in_range)
  );

  // Only the first cycle of a held d_req is a new access.
  assign d_start = bus.d_req & ~d_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      d_req_q <= 1'b0;
      oor_q   <= 1'b0;
      d_we_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      d_req_q <= bus.d_req;
      oor_q   <= oor_d;
      d_we_q  <= d_we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue path. Gated by rst_n so that grants and strobes, which are
  // combinational from the requesters, also drop as soon as reset asserts.
  always_comb begin
    bus.m_req    = 1'b0;
    bus.m_addr   = '0;
    bus.m_we     = 1'b0;
    bus.m_byteen = '0;
    bus.m_wdata  = '0;
    bus.f_gnt    = 1'b0;
    owner_d      = OWN_NONE;
    oor_d        = 1'b0;
    d_we_d       = 1'b0;

    if (rst_n) begin
      if (d_start) begin
        owner_d = OWN_DATA;
        d_we_d  = bus.d_we;
        if (d_in_range) begin
          bus.m_req    = 1'b1;
          bus.m_addr   = bus.d_addr - MEM_BASE;
          bus.m_we     = bus.d_we;
          bus.m_byteen = bus.d_byteen;
          bus.m_wdata  = bus.d_wdata;
        end else begin
          oor_d = 1'b1;
        end
      end else if (bus.f_req) begin
        owner_d   = OWN_FETCH;
        bus.f_gnt = 1'b1;
        if (f_in_range) begin
          bus.m_req    = 1'b1;
          bus.m_addr   = bus.f_addr - MEM_BASE;
          bus.m_byteen = '1;
        end else begin
          oor_d = 1'b1;
        end
      end
    end
  end

  // Response routing: only the owner of this cycle sees anything.
  always_comb begin
    bus.d_rdata  = '0;
    bus.d_err    = 1'b0;
    bus.f_rvalid = 1'b0;
    bus.f_rdata  = '0;
    bus.f_err    = 1'b0;

    unique case (owner_q)
      OWN_DATA: begin
        bus.d_err = oor_q | bus.m_err;
        if (!oor_q && !d_we_q) begin
          bus.d_rdata = bus.m_rdata;
        end
      end
      OWN_FETCH: begin
        bus.f_rvalid = 1'b1;
        bus.f_err    = oor_q | bus.m_err;
        if (!oor_q) begin
          bus.f_rdata = bus.m_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.f_req && !bus.f_gnt && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign fetch_stall_cnt = cnt_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port between the instruction-fetch requester and the load/store ALU's data port.
- Read latency is fixed at 1 cycle. The data port has absolute priority and cannot be stalled; the fetch port uses a req/gnt/rvalid handshake.
- The block detects the start of each data transaction, issues exactly one downstream access per transaction, and routes each response to its owner.
- Accesses outside the configured range are blocked locally and answered with an error at the normal latency.

Parameters:
- MEM_BASE, 32'h0000_0000, first byte address served by the downstream memory.
- MEM_SIZE, 32'h0001_0000, size of the memory window in bytes; must be a power of two and a multiple of 4.
- CNT_W, 16, width of the saturating fetch-stall counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- d_req  in  1  data-port request; held high for exactly 2 cycles per transaction (REQ, WAIT)
- d_addr  in  XLEN  data-port word-aligned address
- d_we  in  1  data-port write enable
- d_byteen  in  XLEN/8  data-port byte enables
- d_wdata  in  XLEN  data-port write data
- d_rdata  out  XLEN  data-port read data, valid in the 2nd request cycle
- d_err  out  1  data-port error, valid in the 2nd request cycle
- f_req  in  1  fetch request; must stay high with f_addr stable until f_gnt
- f_addr  in  XLEN  fetch address (word-aligned)
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid  out  1  fetch response valid, 1 cycle after f_gnt
- f_rdata  out  XLEN  fetch response data
- f_err  out  1  fetch response error, qualified by f_rvalid
- m_req  out  1  downstream access strobe
- m_addr  out  XLEN  downstream address, relative to MEM_BASE
- m_we  out  1  downstream write enable
- m_byteen  out  XLEN/8  downstream byte enables
- m_wdata  out  XLEN  downstream write data
- m_rdata  in  XLEN  downstream read data, 1 cycle after m_req
- m_err  in  1  downstream error, 1 cycle after m_req
- fetch_stall_cnt  out  CNT_W  saturating count of cycles with f_req=1 and f_gnt=0

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; d_req_q=0; resp_owner=NONE; oor_q=0; stall counter 0.
- Reset asserted mid-transaction discards all in-flight responses. The first cycle after reset release is a clean idle.
- Data-start detection: d_start = d_req & ~d_req_q, where d_req_q is d_req registered.
  - The 2nd held cycle (d_req & d_req_q) is not a new access.
  - Consecutive d_start pulses are at least 4 cycles apart; the block need not handle closer spacing.
- Range check, per access: in_range = (addr - MEM_BASE) < MEM_SIZE.
- Arbitration, per cycle:
  - If d_start: issue the data access; f_gnt=0.
  - Else if f_req: issue the fetch access; f_gnt=1.
  - Else: idle.
- Issue rules:
  - If the winner is in range: m_req=1 with the winner's address/we/byteen/wdata. A fetch always has m_we=0 and m_byteen all-ones.
  - If out of range: m_req=0 and oor_q<=1.
  - Either way, resp_owner <= DATA or FETCH for the next cycle.
- Response cycle, resp_owner=DATA:
  - d_rdata = oor_q ? 0 : (d_we_q ? 0 : m_rdata).
  - d_err = oor_q | m_err.
  - This cycle coincides with the data port's 2nd request cycle, so a fetch may be granted in the same cycle (pipelined).
- Response cycle, resp_owner=FETCH: f_rvalid=1; f_rdata = oor_q ? 0 : m_rdata; f_err = oor_q | m_err.
- Output gating: outside their response cycles, d_rdata/d_err are 0 and f_rvalid/f_rdata/f_err are 0.
- Stall counter: increments when f_req & ~f_gnt; saturates at all-ones with no wrap.
- Throughput: fetch sustains 1 access/cycle when the data port is idle. At most 1 fetch cycle is lost per data transaction.
- Writes: exactly one downstream write per data transaction, even though d_req is held 2 cycles.

Decomposition:
- Add to core_config_pkg: typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH} mem_owner_t. Default MEM_BASE/MEM_SIZE constants live there as well.
- Sub-module: mem_range_check, a combinational in_range decode instantiated twice (data and fetch addresses).

Test Plan:
- Fetch-only stream, f_req=1 at 0x100, 0x104, 0x108 on consecutive cycles -> f_gnt=1 each cycle; f_rvalid one cycle later with matching m_rdata; m_req=1 each cycle.
- d_req held 2 cycles (load 0x200) while f_req=1 -> cycle 1: m_addr=0x200, f_gnt=0; cycle 2: fetch granted and d_rdata=mem[0x200]; fetch_stall_cnt=1.
- Store SB 0x23 at 0x201 (byteen=4'b0010, d_req held 2 cycles) -> exactly one m_req with m_we=1, m_byteen=4'b0010; d_rdata=0, d_err=0.
- Load at MEM_BASE+MEM_SIZE -> m_req stays 0; in the 2nd cycle d_err=1, d_rdata=0. Fetch at the same address -> f_rvalid=1, f_err=1.
- m_err=1 on a fetch response -> f_err=1 only; d_err stays 0.
- rst_n pulled low in the cycle after a fetch grant -> f_rvalid never asserts; all outputs 0 asynchronously; normal service resumes after release.
